// File: rtl/sine_table_arbiter_if.sv
// Requester, table and response signals of the shared sine table arbiter.
// slave = the arbiter; master = requesters + table + response consumers.
interface sine_table_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int THETA_W = 10,
    parameter int SINE_W  = 24
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*THETA_W-1:0] req_theta;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tbl_clken;
    logic [THETA_W-1:0]         tbl_theta;
    logic signed [SINE_W-1:0]   tbl_sine;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic signed [SINE_W-1:0]   rsp_sine;

    modport slave (
        input  req_valid, req_theta, tbl_sine,
        output req_ready, tbl_clken, tbl_theta, rsp_valid, rsp_sine
    );

    modport master (
        output req_valid, req_theta, tbl_sine,
        input  req_ready, tbl_clken, tbl_theta, rsp_valid, rsp_sine
    );
endinterface

// File: rtl/sine_table_arbiter.sv
// Round-robin share of one sine table between NUM_REQ requesters; a tag pipeline
// matched to the table latency routes each returned sine to its requester.
module sine_table_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int THETA_W       = 10,
    parameter int SINE_W        = 24,
    parameter int TABLE_LATENCY = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 enable,
    sine_table_arbiter_if.slave  bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = TABLE_LATENCY + 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [THETA_W-1:0]       tbl_theta_q, tbl_theta_d;
    tag_t [DEPTH-1:0]         tag_q, tag_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic signed [SINE_W-1:0] rsp_sine_q, rsp_sine_d;

    logic                     found;
    logic [ID_W-1:0]          grant_id;
    logic [NUM_REQ-1:0]       ready;
    logic                     hs;

    // Search from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        grant_id = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found    = 1'b1;
                grant_id = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        ready = '0;
        if (enable && found && !Reset)
            ready = NUM_REQ'(1) << grant_id;
        hs = |(bus.req_valid & ready);
    end

    always_comb begin
        ptr_d       = ptr_q;
        tbl_theta_d = tbl_theta_q;
        tag_d       = tag_q;
        rsp_valid_d = '0;
        rsp_sine_d  = rsp_sine_q;
        if (hs) begin
            ptr_d       = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            tbl_theta_d = bus.req_theta[grant_id*THETA_W +: THETA_W];
        end
        // The table free-runs with enable, so tags advance only on enabled edges too.
        if (enable) begin
            tag_d[0].vld = hs;
            tag_d[0].id  = grant_id;
            for (int i = 1; i < DEPTH; i++)
                tag_d[i] = tag_q[i-1];
            if (tag_q[DEPTH-1].vld) begin
                rsp_valid_d = NUM_REQ'(1) << tag_q[DEPTH-1].id;
                rsp_sine_d  = bus.tbl_sine;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q       <= '0;
            tbl_theta_q <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sine_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tbl_theta_q <= tbl_theta_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sine_q  <= rsp_sine_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tbl_clken = enable;
    assign bus.tbl_theta = tbl_theta_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sine  = rsp_sine_q;
endmodule

// File: tb/tb_sine_table_arbiter.sv
// Directed bench for sine_table_arbiter with a two-stage behavioural sine table.
module tb_sine_table_arbiter;
    localparam int NR = 4;
    localparam int TW = 10;
    localparam int SW = 24;

    logic Clock, Reset, enable;
    int   n_cmp, n_err;

    sine_table_arbiter_if #(.NUM_REQ(NR), .THETA_W(TW), .SINE_W(SW)) bus();

    sine_table_arbiter #(.NUM_REQ(NR), .THETA_W(TW), .SINE_W(SW), .TABLE_LATENCY(2)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .enable (enable),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Quarter-wave points fixed, other phases get a distinct arbitrary value.
    function automatic logic [SW-1:0] tab(input logic [TW-1:0] th);
        case (th)
            10'd0:   tab = 24'h000000;
            10'd256: tab = 24'h7FFFFF;
            10'd512: tab = 24'h000000;
            10'd768: tab = 24'h800001;
            default: tab = {14'h0, th} * 24'd1000 + 24'd7;
        endcase
    endfunction

    logic [SW-1:0] s1;
    always @(posedge Clock) begin
        if (Reset && !bus.tbl_clken) begin
            s1           <= '0;
            bus.tbl_sine <= '0;
        end else if (bus.tbl_clken) begin
            s1           <= tab(bus.tbl_theta);
            bus.tbl_sine <= s1;
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic set_theta(input int i, input logic [TW-1:0] v);
        bus.req_theta[i*TW +: TW] = v;
    endtask

    task automatic reset_dut;
        Reset = 1'b1; enable = 1'b1; bus.req_valid = '0;
        tick; tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; enable = 1'b1; bus.req_valid = '1;
        for (int i = 0; i < NR; i++) set_theta(i, TW'(i + 5));
        tick;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
            n_cmp++;
            if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
            n_cmp++;
            if (bus.rsp_sine !== 24'h0) begin n_err++; $display("FAIL reset_rsp_sine: got %h expected 000000", bus.rsp_sine); end
            n_cmp++;
            if (bus.tbl_theta !== 10'h0) begin n_err++; $display("FAIL reset_tbl_theta: got %h expected 000", bus.tbl_theta); end
            tick;
        end
        Reset = 1'b0; bus.req_valid = '0;
    endtask

    task automatic test_single;
        reset_dut;
        bus.req_valid = 4'b0100; set_theta(2, 10'd256);
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
                n_err++; $display("FAIL single_rsp_valid c%0d: got %b", c, bus.rsp_valid);
            end
            if (c == 2) begin
                n_cmp++;
                if (bus.tbl_theta !== 10'd256) begin n_err++; $display("FAIL single_tbl_theta: got %0d expected 256", bus.tbl_theta); end
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.rsp_sine !== 24'h7FFFFF) begin n_err++; $display("FAIL single_rsp_sine: got %h expected 7fffff", bus.rsp_sine); end
            end
            tick;
        end
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp_oh;
        reset_dut;
        for (int i = 0; i < NR; i++) set_theta(i, TW'(i * 256));
        for (int c = 0; c < 13; c++) begin
            bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_oh = 4'b0001 << (c % 4);
                n_cmp++;
                if (bus.req_ready !== exp_oh) begin n_err++; $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, exp_oh); end
            end
            exp_oh = (c >= 4 && c < 12) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
            n_cmp++;
            if (bus.rsp_valid !== exp_oh) begin n_err++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, exp_oh); end
            if (c >= 4 && c < 12) begin
                n_cmp++;
                if (bus.rsp_sine !== tab(TW'(((c - 4) % 4) * 256))) begin
                    n_err++; $display("FAIL rr_rsp_sine c%0d: got %h expected %h", c, bus.rsp_sine, tab(TW'(((c - 4) % 4) * 256)));
                end
            end
            tick;
        end
    endtask

    task automatic test_enable_drop;
        reset_dut;
        bus.req_valid = 4'b0010; set_theta(1, 10'd128);
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL en_ready: got %b expected 0010", bus.req_ready); end
        tick;
        bus.req_valid = '0;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL en_rsp_early: got %b expected 0000", bus.rsp_valid); end
        tick;
        enable = 1'b0; bus.req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL en_low_ready c%0d: got %b expected 0000", c, bus.req_ready); end
            n_cmp++;
            if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL en_low_rsp c%0d: got %b expected 0000", c, bus.rsp_valid); end
            n_cmp++;
            if (bus.tbl_clken !== 1'b0) begin n_err++; $display("FAIL en_low_clken c%0d: got %b expected 0", c, bus.tbl_clken); end
            tick;
        end
        enable = 1'b1; bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== ((c == 2) ? 4'b0010 : 4'b0000)) begin
                n_err++; $display("FAIL en_resume_rsp c%0d: got %b", c, bus.rsp_valid);
            end
            if (c == 2) begin
                n_cmp++;
                if (bus.rsp_sine !== tab(10'd128)) begin n_err++; $display("FAIL en_resume_sine: got %h expected %h", bus.rsp_sine, tab(10'd128)); end
            end
            tick;
        end
    endtask

    task automatic test_midflight_reset;
        logic [NR-1:0] exp_oh;
        reset_dut;
        for (int i = 0; i < NR; i++) set_theta(i, TW'(300 + i));
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_oh = 4'b0001 << c;
            n_cmp++;
            if (bus.req_ready !== exp_oh) begin n_err++; $display("FAIL mr_grant c%0d: got %b expected %b", c, bus.req_ready, exp_oh); end
            tick;
        end
        bus.req_valid = '0; Reset = 1'b1;
        tick;
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL mr_no_rsp c%0d: got %b expected 0000", c, bus.rsp_valid); end
            tick;
        end
        bus.req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mr_ptr_zero: got %b expected 0001", bus.req_ready); end
        tick;
        bus.req_valid = '0;
    endtask

    task automatic test_back_to_back;
        reset_dut;
        for (int c = 0; c < 21; c++) begin
            if (c < 16) begin bus.req_valid = 4'b1000; set_theta(3, TW'(c)); end
            else bus.req_valid = '0;
            #1;
            if (c < 16) begin
                n_cmp++;
                if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL b2b_ready c%0d: got %b expected 1000", c, bus.req_ready); end
            end
            n_cmp++;
            if (bus.rsp_valid !== ((c >= 4 && c < 20) ? 4'b1000 : 4'b0000)) begin
                n_err++; $display("FAIL b2b_rsp_valid c%0d: got %b", c, bus.rsp_valid);
            end
            if (c >= 4 && c < 20) begin
                n_cmp++;
                if (bus.rsp_sine !== tab(TW'(c - 4))) begin
                    n_err++; $display("FAIL b2b_rsp_sine c%0d: got %h expected %h", c, bus.rsp_sine, tab(TW'(c - 4)));
                end
            end
            tick;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        Reset = 1'b1; enable = 1'b0;
        bus.req_valid = '0; bus.req_theta = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_enable_drop;
        test_midflight_reset;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
